operand_stack: RTL

OPERAND_STACK -- requirements
Module: operand_stack

---
 rtl/stack_pkg.sv | 36 +++
 rtl/strobe_edge_detect.sv | 29 ++
 rtl/operand_stack.sv | 128 ++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared defaults, pointer width helper and op encoding for operand_stack
//
// Contents:
//   STACK_WIDTH / STACK_DEPTH  default data width and entry count
//   ptr_width()                width of the entry counter (holds 0..DEPTH)
//   stack_op_e / decode_op()   NOP, PUSH, POP, REPLACE decoded from push/pop

package stack_pkg;

  localparam int STACK_WIDTH = 8;
  localparam int STACK_DEPTH = 16;

  // One extra bit so the counter can represent DEPTH itself without wrapping.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    stack_op_e op;
    case ({pop, push})
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      2'b11:   op = OP_REPLACE;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/strobe_edge_detect.sv
// rtl/strobe_edge_detect.sv - rising-edge detector turning stack_clk into a one-cycle strobe
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset (clears stk_q)
//   stack_clk  operation strobe level, already in the clk domain
//   strobe     high for the single cycle where stack_clk rose

module strobe_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic stack_clk,
  output logic strobe
);

  logic stk_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stk_q <= 1'b0;
    end else begin
      stk_q <= stack_clk;
    end
  end

  // stk_q starts at 0, so a stack_clk already high when reset releases fires once.
  assign strobe = stack_clk & ~stk_q;

endmodule

// File: rtl/operand_stack.sv
// rtl/operand_stack.sv - LIFO operand stack with push/pop/replace and error flags
//
// Parameters: WIDTH data width, DEPTH entry count (power of two, 2..256)
// Ports:
//   clk, reset (async active-low), rst (sync clear, active-high)
//   stack_clk             operation strobe; one op per rising edge
//   push, pop             request bits sampled on the strobe edge
//   data_to_push          value written by PUSH / REPLACE
//   data_from_stack       current top entry, 0 when empty
//   count, full, empty    occupancy
//   overflow, underflow   error indications
// Build option: STACK_ERR_STICKY_EN makes overflow/underflow hold until rst/reset;
// otherwise they pulse for one cycle after the offending edge.

module operand_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rst,
  input  logic                         stack_clk,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             data_to_push,
  output logic [WIDTH-1:0]             data_from_stack,
  output logic [ptr_width(DEPTH)-1:0]  count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = ptr_width(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic             strobe;
  stack_op_e        op;
  logic [CW-1:0]    count_nxt;
  logic             ovf_ev;
  logic             unf_ev;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] mem [DEPTH];

  strobe_edge_detect u_edge (
    .clk       (clk),
    .reset     (reset),
    .stack_clk (stack_clk),
    .strobe    (strobe)
  );

  assign op      = decode_op(push, pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign top_idx = AW'(count - 1'b1);

  always_comb begin
    count_nxt = count;
    ovf_ev    = 1'b0;
    unf_ev    = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = AW'(count);
    if (strobe) begin
      case (op)
        OP_PUSH: begin
          if (full) begin
            ovf_ev = 1'b1;
          end else begin
            wr_en     = 1'b1;
            count_nxt = count + 1'b1;
          end
        end
        OP_POP: begin
          if (empty) begin
            unf_ev = 1'b1;
          end else begin
            count_nxt = count - 1'b1;
          end
        end
        OP_REPLACE: begin
          // Replace on an empty stack degenerates to a plain push into slot 0.
          wr_en = 1'b1;
          if (empty) begin
            count_nxt = count + 1'b1;
          end else begin
            wr_idx = top_idx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (rst) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= count_nxt;
`ifdef STACK_ERR_STICKY_EN
      overflow  <= overflow | ovf_ev;
      underflow <= underflow | unf_ev;
`else
      overflow  <= ovf_ev;
      underflow <= unf_ev;
`endif
    end
  end

  // Storage is never reset; count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en && !rst && reset) begin
      mem[wr_idx] <= data_to_push;
    end
  end

  assign data_from_stack = empty ? '0 : mem[top_idx];

endmodule
